gate_chain_accum: RTL and testbench
===================================

# gate_chain_accum

Parametrised, streaming successor to the three-input XNOR/XOR gate problem. Each lane computes f = in3 ^ ~(in1 ^ in2) bitwise over a WIDTH-bit vector. The block either emits f per beat (PASS) or XOR-accumulates f over a frame and emits one result per frame (ACCUM). It sits between a valid/ready stimulus source and a valid/ready consumer, and has a single registered output stage with backpressure.

## Interface
- WIDTH, 8, lanes per beat (≥1)
- FRAME_MAX, 16, maximum beats per ACCUM frame before forced close (≥2)
- CW (derived), $clog2(FRAME_MAX+1), beat counter width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- mode  in  1  0 = PASS, 1 = ACCUM; sampled only on the first beat of a frame
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  final beat of frame
- in1, in2, in3  in  WIDTH  operand vectors
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- dout  out  WIDTH  result vector
- out_last  out  1  result closes a frame
- beat_cnt  out  CW  beats contributing to dout
- overrun  out  1  ACCUM frame force-closed at FRAME_MAX without in_last

## Operation
- f = in3 ^ ~(in1 ^ in2), computed per lane, combinationally from the accepted beat.
- FSM states: IDLE (no frame open) and ACC (ACCUM frame open). The latched mode register (lmode) is valid only in ACC.
- IDLE with an accepted beat and mode=0: load the output register with dout=f, out_last=in_last, beat_cnt=1, overrun=0. Stay in IDLE.
- IDLE with an accepted beat, mode=1, in_last=1: emit a single-beat frame with dout=f, beat_cnt=1, out_last=1. Stay in IDLE.
- IDLE with an accepted beat, mode=1, in_last=0: acc←f, cnt←1, go to ACC. No output.
- ACC with an accepted beat:
  - acc_n = acc ^ f and cnt_n = cnt+1.
  - If in_last, or cnt_n == FRAME_MAX: emit dout=acc_n, beat_cnt=cnt_n, out_last=1, overrun=(!in_last). Go to IDLE.
  - Otherwise update acc and cnt only.
- The mode input is ignored while in ACC.
- Counter never exceeds FRAME_MAX, so beat_cnt has no wrap.

## Timing
- in_ready = !out_valid || out_ready, identical in both states (one-deep output register, no skid).
- Latency: an emitting beat accepted at edge N gives out_valid=1 with data at edge N (visible in the following cycle).
- The output register holds dout, out_last, beat_cnt and overrun stable while out_valid && !out_ready.
- When an output is consumed and a new emitting beat is accepted in the same cycle, the register reloads. out_valid stays 1 with no bubble.
- When an output is consumed and no emitting beat is accepted, out_valid drops to 0 at that edge.
- Non-emitting ACCUM beats still require in_ready.
- Reset values: out_valid=0, dout=0, out_last=0, beat_cnt=0, overrun=0. Internal state: acc=0, cnt=0, FSM=IDLE.
- in_ready is 1 in the cycle after reset.
- Reset asserted mid-frame discards the partial accumulation and any pending output, and overrides a simultaneous handshake.
- in_valid=0 never changes state. Unaccepted beats have no effect.

## Test plan
- PASS, WIDTH=8, out_ready=1: in1=0xF0, in2=0xCC, in3=0xAA → next cycle dout=0x69, out_valid=1, beat_cnt=1, overrun=0. 100 random beats must match the per-lane reference f.
- ACCUM, three beats of all-zero operands, last on beat 3 → one output: dout=0xFF, beat_cnt=3, out_last=1, overrun=0. No out_valid during beats 1–2.
- ACCUM, FRAME_MAX=4, five zero beats with no in_last → output after beat 4 with dout=0x00, beat_cnt=4, overrun=1, out_last=1. Beat 5 opens a new frame, and mode is re-sampled.
- Backpressure, PASS: hold out_ready=0 with in_valid=1 → after the first beat, in_ready=0 and dout stays stable. Release out_ready → back-to-back outputs with no bubble, none lost or duplicated.
- Reset at beat 2 of an ACCUM frame → outputs zero at the next edge. A following single-beat ACCUM frame (in_last=1, zero operands) yields dout=0xFF, beat_cnt=1.
- mode toggled to 0 mid-ACCUM frame → ignored. The frame completes as ACCUM, and PASS behaviour applies only from the next frame.

Source files
------------

// File: rtl/gate_chain_accum_if.sv
// Valid/ready stream bundle for gate_chain_accum: operand beats in, result beats out.
// The slave modport is the block; the master modport is the source/consumer side.
interface gate_chain_accum_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_MAX = 16
);
    localparam int unsigned CW = $clog2(FRAME_MAX + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic             mode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             out_last;
    logic [CW-1:0]    beat_cnt;
    logic             overrun;

    modport master (
        output in_valid, in_last, mode, in1, in2, in3, out_ready,
        input  in_ready, out_valid, dout, out_last, beat_cnt, overrun
    );

    modport slave (
        input  in_valid, in_last, mode, in1, in2, in3, out_ready,
        output in_ready, out_valid, dout, out_last, beat_cnt, overrun
    );
endinterface

// File: rtl/gate_chain_accum.sv
// Per-lane f = in3 ^ ~(in1 ^ in2), emitted per beat (PASS) or XOR-folded over a frame (ACCUM),
// behind a single registered output stage with backpressure.
module gate_chain_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_MAX = 16
) (
    input logic         clk,
    input logic         reset,
    gate_chain_accum_if.slave bus
);
    localparam int unsigned CW = $clog2(FRAME_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             out_last_q, out_last_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             overrun_q, overrun_d;

    logic             in_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] f_c;
    logic [WIDTH-1:0] acc_n_c;
    logic [CW-1:0]    cnt_n_c;
    logic             close_c;

    // One-deep output register: free when empty or being drained this cycle.
    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    always_comb begin
        f_c     = bus.in3 ^ ~(bus.in1 ^ bus.in2);
        acc_n_c = acc_q ^ f_c;
        cnt_n_c = CW'(cnt_q + CW'(1));
        close_c = bus.in_last || (cnt_n_c == CW'(FRAME_MAX));
    end

    // Frame sequencing and output-register load.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        dout_d      = dout_q;
        out_last_d  = out_last_q;
        beat_cnt_d  = beat_cnt_q;
        overrun_d   = overrun_q;

        if (accept_c) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.mode || bus.in_last) begin
                        out_valid_d = 1'b1;
                        dout_d      = f_c;
                        out_last_d  = bus.in_last;
                        beat_cnt_d  = CW'(1);
                        overrun_d   = 1'b0;
                    end else begin
                        acc_d   = f_c;
                        cnt_d   = CW'(1);
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (close_c) begin
                        out_valid_d = 1'b1;
                        dout_d      = acc_n_c;
                        out_last_d  = 1'b1;
                        beat_cnt_d  = cnt_n_c;
                        overrun_d   = !bus.in_last;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = acc_n_c;
                        cnt_d = cnt_n_c;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronous reset wins over any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_last_q  <= 1'b0;
            beat_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_last_q  <= out_last_d;
            beat_cnt_q  <= beat_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_last  = out_last_q;
    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_gate_chain_accum.sv
// Bench for gate_chain_accum (WIDTH=8, FRAME_MAX=4): directed vector table, hand-written
// backpressure/reset sequences, and random traffic against a frame-level reference model.
module tb_gate_chain_accum;
    localparam int unsigned W  = 8;
    localparam int unsigned FM = 4;
    localparam int unsigned CW = $clog2(FM + 1);

    logic clk;
    logic reset;

    gate_chain_accum_if #(.WIDTH(W), .FRAME_MAX(FM)) bus ();

    gate_chain_accum #(.WIDTH(W), .FRAME_MAX(FM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  dout;
        logic          last;
        logic [CW-1:0] cnt;
        logic          ov;
    } out_t;

    typedef struct {
        logic          mode;
        logic          last;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic          ev;
        logic [W-1:0]  ed;
        logic          el;
        logic [CW-1:0] ec;
        logic          eo;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected output queue plus the currently open ACCUM frame.
    out_t         exp_q[$];
    bit           m_open;
    logic [W-1:0] m_acc;
    int           m_n;

    function automatic logic [W-1:0] lane_f(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) begin
            int s;
            s = int'(a[i]) + int'(b[i]) + int'(c[i]) + 1;
            r[i] = (s % 2) == 1;
        end
        return r;
    endfunction

    task automatic check(string name, bit ok, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_open = 0;
        m_acc  = '0;
        m_n    = 0;
    endtask

    task automatic model_beat(logic mode, logic last, logic [W-1:0] f);
        if (!m_open) begin
            if (!mode || last) begin
                exp_q.push_back('{dout: f, last: last, cnt: CW'(1), ov: 1'b0});
            end else begin
                m_open = 1;
                m_acc  = f;
                m_n    = 1;
            end
        end else begin
            m_acc = m_acc ^ f;
            m_n   = m_n + 1;
            if (last || m_n == int'(FM)) begin
                exp_q.push_back('{dout: m_acc, last: 1'b1, cnt: CW'(m_n), ov: !last});
                m_open = 0;
            end
        end
    endtask

    // One clock: check handshake/outputs against the model, advance the model, clock the DUT.
    task automatic cycle();
        bit   ev;
        out_t act;
        #1;
        ev = (exp_q.size() != 0);
        check("out_valid", bus.out_valid == ev, 32'(bus.out_valid), 32'(ev));
        check("in_ready", bus.in_ready == (!ev || bus.out_ready),
              32'(bus.in_ready), 32'(!ev || bus.out_ready));
        if (bus.out_valid && bus.out_ready && ev) begin
            act = '{dout: bus.dout, last: bus.out_last, cnt: bus.beat_cnt, ov: bus.overrun};
            check("out_beat", act == exp_q[0], 32'(act), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready)
            model_beat(bus.mode, bus.in_last, lane_f(bus.in1, bus.in2, bus.in3));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic mode, logic last, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] c, logic ordy);
        bus.in_valid  = v;
        bus.mode      = mode;
        bus.in_last   = last;
        bus.in1       = a;
        bus.in2       = b;
        bus.in3       = c;
        bus.out_ready = ordy;
    endtask

    task automatic check_zero_outputs(string name);
        out_t act;
        act = '{dout: bus.dout, last: bus.out_last, cnt: bus.beat_cnt, ov: bus.overrun};
        check(name, !bus.out_valid && act == '0 && bus.in_ready,
              {bus.out_valid, bus.in_ready, 17'(act)}, 32'h2_0000);
    endtask

    vec_t vt[13];

    initial begin
        logic [W-1:0] held;

        drive(0, 0, 0, '0, '0, '0, 1);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_zero_outputs("reset_state");

        // Directed table; out_ready held at 1, every row a valid beat.
        vt[0]  = '{0, 1, 8'hF0, 8'hCC, 8'hAA, 1, 8'h69, 1, 3'd1, 0};
        vt[1]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[2]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[3]  = '{1, 1, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 1, 3'd3, 0};
        vt[4]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[5]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[6]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[7]  = '{1, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1, 3'd4, 1};
        vt[8]  = '{0, 0, 8'h12, 8'h34, 8'h56, 1, 8'h8F, 0, 3'd1, 0};
        vt[9]  = '{1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[10] = '{0, 0, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0, 0};
        vt[11] = '{0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h00, 1, 3'd3, 0};
        vt[12] = '{0, 1, 8'hF0, 8'hCC, 8'hAA, 1, 8'h69, 1, 3'd1, 0};

        for (int i = 0; i < 13; i++) begin
            out_t act, req;
            drive(1, vt[i].mode, vt[i].last, vt[i].a, vt[i].b, vt[i].c, 1);
            cycle();
            act = '{dout: bus.dout, last: bus.out_last, cnt: bus.beat_cnt, ov: bus.overrun};
            req = '{dout: vt[i].ed, last: vt[i].el, cnt: vt[i].ec, ov: vt[i].eo};
            if (!vt[i].ev)
                check($sformatf("vec%0d_idle", i), !bus.out_valid, 32'(bus.out_valid), 32'd0);
            else
                check($sformatf("vec%0d", i), bus.out_valid && act == req,
                      {bus.out_valid, 17'(act)}, {1'b1, 17'(req)});
        end
        drive(0, 0, 0, '0, '0, '0, 1);
        cycle();

        // Backpressure in PASS: first beat fills the register, later beats must wait.
        drive(1, 0, 0, 8'h11, 8'h22, 8'h33, 0);
        cycle();
        held = bus.dout;
        check("bp_first", bus.out_valid && held == lane_f(8'h11, 8'h22, 8'h33),
              32'(held), 32'(lane_f(8'h11, 8'h22, 8'h33)));
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 8'(8'h40 + k), 8'h5A, 8'hC3, 0);
            cycle();
            check("bp_hold", !bus.in_ready && bus.out_valid && bus.dout == held,
                  {bus.in_ready, bus.out_valid, 8'(bus.dout)}, {2'b01, 8'(held)});
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, k == 3, 8'(8'h40 + k), 8'h5A, 8'hC3, 1);
            cycle();
            check("bp_no_bubble", bus.out_valid == 1'b1, 32'(bus.out_valid), 32'd1);
        end
        drive(0, 0, 0, '0, '0, '0, 1);
        cycle();
        cycle();

        // Reset on beat 2 of an ACCUM frame discards the partial frame.
        drive(1, 1, 0, 8'h00, 8'h00, 8'h00, 1);
        cycle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("reset_midframe");
        drive(1, 1, 1, 8'h00, 8'h00, 8'h00, 1);
        cycle();
        check("post_reset_frame",
              bus.out_valid && bus.dout == 8'hFF && bus.beat_cnt == CW'(1) && bus.out_last,
              {bus.out_valid, bus.out_last, 3'(bus.beat_cnt), 8'(bus.dout)},
              {1'b1, 1'b1, 3'd1, 8'hFF});
        drive(0, 0, 0, '0, '0, '0, 1);
        cycle();

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) == 0,
                  8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
            cycle();
        end
        drive(0, 0, 0, '0, '0, '0, 1);
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
